// File: rtl/afpm_pkg.sv
// Shared definitions for the logarithmic approximate FP16 multiplier.
// Contents:
//   - state_t  : byte-serial sequencer states (load two bytes, emit two bytes)
//   - FP16 constants used by the Mitchell multiplier datapath
package afpm_pkg;

  typedef enum logic [1:0] {
    LOAD_LO = 2'd0,
    LOAD_HI = 2'd1,
    OUT_LO  = 2'd2,
    OUT_HI  = 2'd3
  } state_t;

  // Exponent bias (15) placed at the exponent field position (<<10).
  localparam logic [15:0] BIAS_SHIFTED = 16'h3C00;
  // Smallest magnitude sum whose rebiased exponent is still >= 1.
  localparam logic [15:0] MIN_NORM_SUM = 16'h4000;
  localparam logic [15:0] INF          = 16'h7C00;
  localparam logic [15:0] QNAN         = 16'h7E00;
  localparam logic [4:0]  EXP_MAX      = 5'd31;

endpackage

// File: rtl/fp16_log_mul.sv
// Combinational approximate FP16 multiplier (Mitchell's logarithmic method).
// Adding the two 15-bit magnitude fields adds the exponents and, to first
// order, the log2 of the mantissas; the mantissa carry rippling into the
// exponent is exactly the Mitchell approximation. Subnormals flush to zero,
// no rounding is performed.
// Ports:
//   a, b : FP16 operands
//   p    : FP16 approximate product
module fp16_log_mul
  import afpm_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] p
);

  logic        sign;
  logic [4:0]  exp_a;
  logic [4:0]  exp_b;
  logic        a_nan;
  logic        b_nan;
  logic        a_inf;
  logic        b_inf;
  logic        a_zero;
  logic        b_zero;
  logic [15:0] mag_sum;
  logic [15:0] rebiased;

  assign sign   = a[15] ^ b[15];
  assign exp_a  = a[14:10];
  assign exp_b  = b[14:10];
  assign a_nan  = (exp_a == EXP_MAX) && (a[9:0] != 10'd0);
  assign b_nan  = (exp_b == EXP_MAX) && (b[9:0] != 10'd0);
  assign a_inf  = (exp_a == EXP_MAX) && (a[9:0] == 10'd0);
  assign b_inf  = (exp_b == EXP_MAX) && (b[9:0] == 10'd0);
  // Exponent 0 covers both true zero and subnormals (flushed to zero).
  assign a_zero = (exp_a == 5'd0);
  assign b_zero = (exp_b == 5'd0);

  assign mag_sum  = {1'b0, a[14:0]} + {1'b0, b[14:0]};
  // Only meaningful once mag_sum >= MIN_NORM_SUM, so no underflow wrap matters.
  assign rebiased = mag_sum - BIAS_SHIFTED;

  always_comb begin
    p = 16'h0000;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      p = QNAN;
    end else if (a_inf || b_inf) begin
      p = {sign, INF[14:0]};
    end else if (a_zero || b_zero) begin
      p = {sign, 15'h0000};
    end else if (mag_sum < MIN_NORM_SUM) begin
      p = {sign, 15'h0000};
    end else if (rebiased >= INF) begin
      p = {sign, INF[14:0]};
    end else begin
      p = {sign, rebiased[14:0]};
    end
  end

endmodule

// File: rtl/logarithmic_afpm.sv
// Byte-serial approximate FP16 multiplier tile.
// Operands arrive low byte first on ui_in (A) and uio_in (B), one byte per
// enabled clock; the product streams out low byte first on uo_out. The
// sequence free-runs LOAD_LO -> LOAD_HI -> OUT_LO -> OUT_HI while ena is high.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset (overrides ena)
//   ena     : enable; low freezes all state
//   ui_in   : operand A byte stream
//   uio_in  : operand B byte stream
//   uo_out  : registered product byte stream
//   uio_out : tied 0x00
//   uio_oe  : tied 0x00 (bidirectional pins are inputs)
module logarithmic_afpm
  import afpm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t      state_reg;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [15:0] product;

  fp16_log_mul u_mul (
    .a (a_reg),
    .b (b_reg),
    .p (product)
  );

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LOAD_LO;
      a_reg     <= 16'h0000;
      b_reg     <= 16'h0000;
      uo_out    <= 8'h00;
    end else if (ena) begin
      unique case (state_reg)
        LOAD_LO: begin
          a_reg[7:0] <= ui_in;
          b_reg[7:0] <= uio_in;
          state_reg  <= LOAD_HI;
        end
        LOAD_HI: begin
          a_reg[15:8] <= ui_in;
          b_reg[15:8] <= uio_in;
          state_reg   <= OUT_LO;
        end
        OUT_LO: begin
          uo_out    <= product[7:0];
          state_reg <= OUT_HI;
        end
        OUT_HI: begin
          uo_out    <= product[15:8];
          state_reg <= LOAD_LO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logarithmic_afpm.sv
// Self-checking bench for logarithmic_afpm: directed corner cases, enable
// stall, mid-output reset, then random operand pairs, all checked against a
// field-level arithmetic model of the approximate product.
module tb_logarithmic_afpm;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  logarithmic_afpm dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Reference: exponents add (minus bias), mantissa fractions add, and a
  // fraction overflow bumps the exponent by one.
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, e, m;
    logic s;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = int'(a[9:0]);
    mb = int'(b[9:0]);
    if ((ea == 31 && ma != 0) || (eb == 31 && mb != 0)) return 16'h7E00;
    if ((ea == 31 && eb == 0) || (eb == 31 && ea == 0)) return 16'h7E00;
    if (ea == 31 || eb == 31) return {s, 15'h7C00};
    if (ea == 0 || eb == 0) return {s, 15'h0000};
    e = ea + eb - 15;
    m = ma + mb;
    if (m >= 1024) begin
      e = e + 1;
      m = m - 1024;
    end
    if (e <= 0) return {s, 15'h0000};
    if (e >= 31) return {s, 15'h7C00};
    return {s, 5'(e), 10'(m)};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 4-edge transaction; optional stall of ena between LOAD_HI and OUT_LO.
  task automatic run_pair(input logic [15:0] a, input logic [15:0] b, input int stall);
    logic [15:0] p;
    logic [7:0]  held;
    p      = model(a, b);
    ui_in  = a[7:0];
    uio_in = b[7:0];
    tick();
    ui_in  = a[15:8];
    uio_in = b[15:8];
    tick();
    held = uo_out;
    if (stall > 0) begin
      ena    = 1'b0;
      ui_in  = 8'hA5;
      uio_in = 8'h5A;
      for (int i = 0; i < stall; i++) tick();
      check("stall_hold", uo_out, held);
      ena = 1'b1;
    end
    tick();
    check("p_lo", uo_out, p[7:0]);
    tick();
    check("p_hi", uo_out, p[15:8]);
    $display("txn a=%04h b=%04h expected_p=%04h", a, b, p);
  endtask

  logic [15:0] dir_a [11] = '{16'h3E00, 16'h3C00, 16'h3E00, 16'h0000, 16'h8000, 16'h0200,
                             16'h7800, 16'h0400, 16'h7C00, 16'hFC00, 16'h7C01};
  logic [15:0] dir_b [11] = '{16'h4200, 16'hC500, 16'h3E00, 16'h4200, 16'h4200, 16'h3C00,
                             16'h7800, 16'h0400, 16'h0000, 16'h4000, 16'h3C00};

  initial begin
    logic [15:0] ra, rb;
    rst    = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    check("reset_uo", uo_out, 8'h00);
    check("uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'h00);

    // Spot-check the first documented product against its literal value.
    run_pair(16'h3E00, 16'h4200, 0);
    check("lit_4400", uo_out, 8'h44);

    for (int i = 0; i < 11; i++) run_pair(dir_a[i], dir_b[i], 0);

    run_pair(16'h3E00, 16'h4200, 3);

    // Reset mid-output: load a pair, assert rst in OUT_LO.
    ui_in  = 8'h00;
    uio_in = 8'h00;
    tick();
    ui_in  = 8'h7C;
    uio_in = 8'h7C;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_uo", uo_out, 8'h00);
    run_pair(16'h3C00, 16'hC500, 0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_pair(ra, rb, (i % 10 == 5) ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
